ysyx_23060180_mem_arbiter: RTL

Two-requester arbiter that shares the core's single memory port between instruction fetch (port 0) and load/store (port 1). It accepts at most one transaction at a time and drives the memory command for exactly one cycle. It counts the fixed memory read latency and returns the response to the requester that owns the transaction. It sits between the CPU core's fetch/LSU request interfaces and the memory model reached over DPI.

---
 rtl/ysyx_23060180_mem_pkg.sv | 18 +
 rtl/ysyx_23060180_rr_arb2.sv | 47 ++++
 rtl/ysyx_23060180_mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ysyx_23060180_mem_pkg.sv
// Shared definitions for the memory arbiter slice.
//   arb_state_e     : arbiter transaction state
//   PORT_IF/LSU     : requester indices (fetch = 0, load/store = 1)
//   MEM_LAT_DEFAULT : default memory read latency in cycles
package ysyx_23060180_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam int PORT_IF         = 0;
   localparam int PORT_LSU        = 1;
   localparam int MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/ysyx_23060180_rr_arb2.sv
// Two-way combinational grant with a registered last-grant pointer.
//   clk, rstn_in : clock, async active-low reset
//   en_i         : grants are only issued while enabled
//   req_i        : per-port request (bit i = port i)
//   gnt_o        : one-hot or zero grant
// RR_EN=1 alternates between ports under contention; RR_EN=0 lets the
// LSU port win every contention.
module ysyx_23060180_rr_arb2
   import ysyx_23060180_mem_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rstn_in,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic       last_q, last_d;
   logic [1:0] gnt;

   always_comb begin
      gnt = 2'b00;
      case (req_i)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // Under contention the port not granted last time wins.
         2'b11:   gnt = (RR_EN && (last_q == 1'(PORT_LSU))) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   assign gnt_o = en_i ? gnt : 2'b00;

   always_comb begin
      last_d = last_q;
      if (|(req_i & gnt_o)) last_d = gnt_o[1];
   end

   // Pointer resets to "LSU granted last" so fetch gets first priority.
   always_ff @(posedge clk or negedge rstn_in) begin
      if (!rstn_in) last_q <= 1'(PORT_LSU);
      else          last_q <= last_d;
   end

endmodule

// File: rtl/ysyx_23060180_mem_arbiter.sv
// Shares the single memory port between instruction fetch (port 0) and
// load/store (port 1). One transaction in flight at a time.
//   clk, rstn_in             : clock, async active-low reset
//   req_valid/ready/wr       : per-port handshake and direction
//   req_addr/wdata/wstrb     : per-port request fields, sampled on accept
//   resp_valid, resp_rdata   : one-cycle response pulse to the owner
//   mem_rd, mem_wr           : one-cycle memory strobes
//   mem_addr/wdata/wstrb     : registered memory command fields
//   mem_rdata                : memory read data, MEM_LAT cycles after mem_rd
//
// state | meaning
// IDLE  | arbitrating, req_ready may be high
// ISSUE | strobe mem_rd or mem_wr for one cycle
// WAIT  | counting read latency, capture mem_rdata on the last cycle
// RESP  | pulse resp_valid to the owner
module ysyx_23060180_mem_arbiter
   import ysyx_23060180_mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = MEM_LAT_DEFAULT,
   parameter bit RR_EN   = 1'b1
) (
   input  logic                       clk,
   input  logic                       rstn_in,
   input  logic [1:0]                 req_valid,
   output logic [1:0]                 req_ready,
   input  logic [1:0]                 req_wr,
   input  logic [1:0][ADDR_W-1:0]     req_addr,
   input  logic [1:0][DATA_W-1:0]     req_wdata,
   input  logic [1:0][DATA_W/8-1:0]   req_wstrb,
   output logic [1:0]                 resp_valid,
   output logic [DATA_W-1:0]          resp_rdata,
   output logic                       mem_rd,
   output logic                       mem_wr,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic [DATA_W/8-1:0]        mem_wstrb,
   input  logic [DATA_W-1:0]          mem_rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(MEM_LAT);

   arb_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                owner_q;
   logic                wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [1:0]          gnt;
   logic                accept;
   logic                sel;
   logic                capture;

   // Gating with rstn_in keeps req_ready low while reset is held.
   ysyx_23060180_rr_arb2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .clk     (clk),
      .rstn_in (rstn_in),
      .en_i    ((state_q == IDLE) && rstn_in),
      .req_i   (req_valid),
      .gnt_o   (gnt)
   );

   assign req_ready = gnt;
   assign accept    = |(req_valid & gnt);
   assign sel       = gnt[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = ISSUE;
         end
         ISSUE: begin
            if (wr_q) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
               cnt_d   = LAT_LD;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               capture = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            owner_q <= sel;
            wr_q    <= req_wr[sel];
            addr_q  <= req_addr[sel];
            wdata_q <= req_wdata[sel];
            // Reads present an all-zero byte enable to memory.
            wstrb_q <= req_wr[sel] ? req_wstrb[sel] : '0;
         end
         if (capture) rdata_q <= mem_rdata;
      end
   end

   assign mem_rd    = (state_q == ISSUE) && !wr_q;
   assign mem_wr    = (state_q == ISSUE) &&  wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

   always_comb begin
      resp_valid = 2'b00;
      if (state_q == RESP) resp_valid[owner_q] = 1'b1;
   end

   // Write acks return zero data; otherwise the last captured read is held.
   assign resp_rdata = ((state_q == RESP) && wr_q) ? '0 : rdata_q;

endmodule
